fir_src_gen: RTL and testbench

Test-stimulus sample generator that drives the 16-bit sample input of the team's direct-form FIR filter. On a start command it emits a programmable sequence (impulse, step, ramp or square) for a set length at a programmable sample period. It then emits a zero tail long enough to drain the filter's delay line, and signals completion. It is the writer side of the filter's sample interface: it sits between the test controller and the filter's input port.

---
 rtl/fir_src_gen.sv | 168 ++++++++++++++++
 tb/tb_fir_src_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_src_gen.sv
// Stimulus generator for the FIR sample input: emits an impulse, step, ramp or square
// sequence at a programmable period, then a zero tail to drain the filter delay line.
module fir_src_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int DIV_WIDTH  = 8,
    parameter int FLUSH_LEN  = 9,
    parameter int HALF_PER   = 8
) (
    input  logic                  sclk,
    input  logic                  s_rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] amp,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DIV_WIDTH-1:0]  div,
    output logic [DATA_WIDTH-1:0] smp_out,
    output logic                  smp_vld,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] amp_q, amp_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [LEN_WIDTH-1:0]  k_q, k_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] smp_out_q, smp_out_d;
    logic                  smp_vld_q, smp_vld_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // acc_v carries k*amp (mod 2^DATA_WIDTH) so the ramp needs no multiplier
    function automatic logic [DATA_WIDTH-1:0] wave_val(
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] a,
        input logic [LEN_WIDTH-1:0]  k,
        input logic [DATA_WIDTH-1:0] acc_v
    );
        logic [LEN_WIDTH-1:0] half_idx;
        half_idx = k / LEN_WIDTH'(HALF_PER);
        case (m)
            2'd0:    return (k == '0) ? a : '0;
            2'd1:    return a;
            2'd2:    return acc_v;
            default: return half_idx[0] ? '0 : a;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        amp_d     = amp_q;
        len_d     = len_q;
        div_d     = div_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        smp_out_d = smp_out_q;
        smp_vld_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                smp_out_d = '0;
                busy_d    = 1'b0;
                if (start) begin
                    mode_d    = mode;
                    amp_d     = amp;
                    len_d     = len;
                    div_d     = div;
                    k_d       = '0;
                    cnt_d     = '0;
                    acc_d     = '0;
                    busy_d    = 1'b1;
                    smp_vld_d = 1'b1;
                    if (len != '0) begin
                        state_d   = RUN;
                        smp_out_d = wave_val(mode, amp, '0, '0);
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            RUN: begin
                if (cnt_q == div_q) begin
                    cnt_d     = '0;
                    smp_vld_d = 1'b1;
                    if (k_q == len_q - LEN_WIDTH'(1)) begin
                        state_d   = FLUSH;
                        k_d       = '0;
                        acc_d     = '0;
                        smp_out_d = '0;
                    end else begin
                        k_d       = k_q + LEN_WIDTH'(1);
                        acc_d     = acc_q + amp_q;
                        smp_out_d = wave_val(mode_q, amp_q, k_q + LEN_WIDTH'(1), acc_q + amp_q);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            FLUSH: begin
                if (cnt_q == div_q) begin
                    cnt_d     = '0;
                    smp_out_d = '0;
                    if (k_q == LEN_WIDTH'(FLUSH_LEN - 1)) begin
                        state_d = DONE;
                        k_d     = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d       = k_q + LEN_WIDTH'(1);
                        smp_vld_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                smp_out_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            amp_q     <= '0;
            len_q     <= '0;
            div_q     <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            smp_out_q <= '0;
            smp_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            amp_q     <= amp_d;
            len_q     <= len_d;
            div_q     <= div_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            smp_out_q <= smp_out_d;
            smp_vld_q <= smp_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign smp_out = smp_out_q;
    assign smp_vld = smp_vld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fir_src_gen.sv
// Scoreboard bench for fir_src_gen: directed runs push expected samples and done times;
// a negedge monitor pops and compares on every strobe and done pulse.
module tb_fir_src_gen;

    logic        sclk = 1'b0;
    logic        s_rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] amp;
    logic [15:0] len;
    logic [7:0]  div;
    logic [15:0] smp_out;
    logic        smp_vld;
    logic        busy;
    logic        done;

    fir_src_gen dut (
        .sclk    (sclk),
        .s_rst   (s_rst),
        .start   (start),
        .mode    (mode),
        .amp     (amp),
        .len     (len),
        .div     (div),
        .smp_out (smp_out),
        .smp_vld (smp_vld),
        .busy    (busy),
        .done    (done)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          dq[$];
    logic [15:0] stg[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] last_v = '0;

    always @(posedge sclk) cyc <= cyc + 1;

    // Monitor: strobes, done pulses and hold-between-strobes
    always @(negedge sclk) begin
        exp_t e;
        int   dc;
        if (smp_vld) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: got %h at cycle %0d, none expected", smp_out, cyc);
            end else begin
                e = sb.pop_front();
                if (smp_out !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL sample: got %h at cycle %0d, expected %h at cycle %0d",
                             smp_out, cyc, e.val, e.cyc);
                end
            end
            last_v = smp_out;
        end else if (busy) begin
            checks++;
            if (smp_out !== last_v) begin
                errors++;
                $display("FAIL hold: got %h at cycle %0d, expected held %h", smp_out, cyc, last_v);
            end
        end
        if (done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
            end else begin
                dc = dq.pop_front();
                if (cyc != dc || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done: at cycle %0d busy=%b, expected cycle %0d busy=0", cyc, busy, dc);
                end
            end
        end
    end

    task automatic ev(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) stg.push_back(v);
    endtask

    // Start a run; staged values become scoreboard entries at t+1+n*P
    task automatic go(input logic [1:0] m, input logic [15:0] a, input logic [15:0] l,
                      input logic [7:0] d, input bit exp_done, input int total);
        int p;
        int t;
        p = int'(d) + 1;
        @(negedge sclk);
        t = cyc;
        for (int n = 0; n < stg.size(); n++) sb.push_back('{val: stg[n], cyc: t + 1 + n * p});
        if (exp_done) dq.push_back(t + 1 + total * p);
        stg.delete();
        mode  = m;
        amp   = a;
        len   = l;
        div   = d;
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        mode  = ~m;
        amp   = 16'hFFFF;
        len   = 16'd3;
        div   = 8'd0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, expected 1", busy);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || dq.size() != 0) && n < limit) begin
            @(negedge sclk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d samples and %0d done pending, expected 0", sb.size(), dq.size());
        end
        repeat (3) @(negedge sclk);
    endtask

    initial begin
        s_rst = 1'b1;
        start = 1'b0;
        mode  = '0;
        amp   = '0;
        len   = '0;
        div   = '0;
        repeat (3) @(negedge sclk);
        checks++;
        if ({smp_out, smp_vld, busy, done} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got out=%h vld=%b busy=%b done=%b, expected all 0",
                     smp_out, smp_vld, busy, done);
        end
        s_rst = 1'b0;
        repeat (2) @(negedge sclk);

        // impulse: 1 then 9 zeros, done at t+11
        ev(16'd1, 1); ev(16'd0, 9);
        go(2'd0, 16'd1, 16'd1, 8'd0, 1'b1, 10);
        wait_drain(100);

        // ramp wrap
        ev(16'h0000, 1); ev(16'h4000, 1); ev(16'h8000, 1); ev(16'hC000, 1); ev(16'h0000, 1);
        ev(16'd0, 9);
        go(2'd2, 16'h4000, 16'd5, 8'd0, 1'b1, 14);
        wait_drain(100);

        // divider hold, P=4
        ev(16'd100, 2); ev(16'd0, 9);
        go(2'd1, 16'd100, 16'd2, 8'd3, 1'b1, 11);
        wait_drain(200);

        // square, half period 8
        ev(16'd7, 8); ev(16'd0, 8); ev(16'd7, 4); ev(16'd0, 9);
        go(2'd3, 16'd7, 16'd20, 8'd0, 1'b1, 29);
        wait_drain(200);

        // len=0: flush only, done at t+10
        ev(16'd0, 9);
        go(2'd1, 16'd55, 16'd0, 8'd0, 1'b1, 9);
        wait_drain(100);

        // second start mid-run is ignored
        ev(16'd3, 6); ev(16'd0, 9);
        go(2'd1, 16'd3, 16'd6, 8'd1, 1'b1, 15);
        repeat (2) @(negedge sclk);
        mode  = 2'd2;
        amp   = 16'd50;
        len   = 16'd2;
        start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        wait_drain(200);

        // reset during sample 3 of a P=2 run (sample 3 shown in cycles t+7,t+8)
        ev(16'd5, 4);
        go(2'd1, 16'd5, 16'd10, 8'd1, 1'b0, 0);
        repeat (6) @(negedge sclk);
        #1 s_rst = 1'b1;
        @(posedge sclk);
        #1;
        checks++;
        if ({smp_out, smp_vld, busy, done} !== 19'd0) begin
            errors++;
            $display("FAIL reset_midrun: got out=%h vld=%b busy=%b done=%b, expected all 0",
                     smp_out, smp_vld, busy, done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_sample3_seen: %0d samples pending, expected 0", sb.size());
        end
        @(negedge sclk);
        s_rst = 1'b0;
        sb.delete();
        repeat (30) @(negedge sclk);

        // fresh impulse run after reset
        ev(16'd1, 1); ev(16'd0, 9);
        go(2'd0, 16'd1, 16'd1, 8'd0, 1'b1, 10);
        wait_drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
